// File: rtl/ysyx_25020047_ifu.sv
// ysyx_25020047_ifu: instruction fetch unit, one outstanding word fetch feeding a one-entry buffer toward decode
module ysyx_25020047_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n, inst_n, inst_pc_n;
    logic        drop, drop_n, fault_n;
    logic        misaligned, req_fire;

    assign misaligned     = |fetch_pc[1:0];
    assign imem_req_valid = (state == REQ) && !misaligned;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Next-state logic; a redirect overrides the normal transition and leaves a drop
    // marker only when a request is (or stays) in flight without its response.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        inst_n     = inst;
        inst_pc_n  = inst_pc;
        fault_n    = fetch_fault;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (misaligned) begin
                    state_n    = HOLD;
                    inst_n     = 32'h0;
                    inst_pc_n  = fetch_pc;
                    fault_n    = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                end else if (imem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    drop_n = 1'b0;
                    if (drop) begin
                        state_n = REQ;
                    end else begin
                        state_n    = HOLD;
                        inst_n     = imem_resp_data;
                        inst_pc_n  = fetch_pc;
                        fault_n    = imem_resp_err;
                        fetch_pc_n = fetch_pc + 32'd4;
                    end
                end
            end
            HOLD: state_n = inst_ready ? REQ : HOLD;
            default: state_n = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
            state_n    = ((state == REQ && req_fire) || (state == WAIT && !imem_resp_valid)) ? WAIT : REQ;
            drop_n     = (state_n == WAIT);
        end
    end

    // State and buffer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            drop        <= 1'b0;
            inst        <= 32'h0;
            inst_pc     <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            drop        <= drop_n;
            inst        <= inst_n;
            inst_pc     <= inst_pc_n;
            fetch_fault <= fault_n;
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// tb_ysyx_25020047_ifu: directed bench with a stream-level fetch model and a latency-configurable memory
module tb_ysyx_25020047_ifu;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;
    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        imem_resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    ysyx_25020047_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 0;
    int          hs = 0;
    int          h = 0;
    bit          spur = 1'b0;
    bit          seen_dead = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] q_addr[$];
    int          q_due[$];

    // Memory contents: a couple of pinned words, everything else derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_000C) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Stream model: decode must see consecutive PCs from the last redirect (or reset),
    // each carrying the memory word or a fault; requests always target that PC.
    task automatic monitor();
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            exp_pc = RST_PC;
            return;
        end
        if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_word(exp_pc));
            chk("fault", {31'h0, fetch_fault}, {31'h0, (exp_pc[1:0] != 2'b00) || (exp_pc == ERR_ADDR)});
            if (inst == 32'hDEAD_BEEF) seen_dead = 1'b1;
        end
        if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, exp_pc);
            chk("req_aligned", {30'h0, imem_req_addr[1:0]}, 32'h0);
            chk("one_outstanding", q_addr.size(), 0);
        end
        if (imem_resp_valid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + 1 + lat);
        end
        if (inst_valid && inst_ready) begin
            hs++;
            exp_pc += 32'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
    endtask

    // One clock: check/model at the falling edge, then drive memory outputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(q_addr[0]);
            imem_resp_err   = (q_addr[0] == ERR_ADDR);
        end else if (spur) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h0BAD_0BAD;
            imem_resp_err   = 1'b1;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            imem_resp_err   = 1'b0;
        end
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        chk(name, {31'h0, inst_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
        // first fetch, zero-wait memory
        rst = 1'b0;
        chk("t1_idle_no_req", {31'h0, imem_req_valid}, 32'h0);
        step();
        chk("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t1_req_addr", imem_req_addr, 32'h8000_0000);
        step();
        chk("t1_wait_no_inst", {31'h0, inst_valid}, 32'h0);
        step();
        chk("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("t1_inst", inst, 32'h0000_0413);
        chk("t1_inst_pc", inst_pc, 32'h8000_0000);
        step();
        chk("t1_next_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t1_next_addr", imem_req_addr, 32'h8000_0004);
        // request backpressure, then decode backpressure with stray responses
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_req_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("t2_req_addr", imem_req_addr, 32'h8000_0004);
        end
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        step();
        step();
        spur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("t2_hold_pc", inst_pc, 32'h8000_0004);
            chk("t2_hold_inst", inst, 32'hDA5A_1230);
            chk("t2_hold_no_req", {31'h0, imem_req_valid}, 32'h0);
            step();
        end
        spur = 1'b0;
        inst_ready = 1'b1;
        step();
        chk("t2_next_addr", imem_req_addr, 32'h8000_0008);
        // memory access fault
        step();
        step();
        chk("t5_valid", {31'h0, inst_valid}, 32'h1);
        chk("t5_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t5_pc", inst_pc, 32'h8000_0008);
        step();
        chk("t5_next_addr", imem_req_addr, 32'h8000_000C);
        // redirect while waiting, stale response two cycles later
        lat = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        lat = 0;
        chk("t3_no_inst", {31'h0, inst_valid}, 32'h0);
        chk("t3_no_req", {31'h0, imem_req_valid}, 32'h0);
        step();
        chk("t3_stale_no_inst", {31'h0, inst_valid}, 32'h0);
        step();
        chk("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t3_req_addr", imem_req_addr, 32'h8000_0100);
        chk("t3_still_no_inst", {31'h0, inst_valid}, 32'h0);
        // redirect in HOLD without consumption
        inst_ready = 1'b0;
        step();
        step();
        chk("t4a_valid", {31'h0, inst_valid}, 32'h1);
        chk("t4a_pc", inst_pc, 32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0180;
        h = hs;
        step();
        redirect_valid = 1'b0;
        chk("t4a_squash", {31'h0, inst_valid}, 32'h0);
        chk("t4a_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t4a_req_addr", imem_req_addr, 32'h8000_0180);
        chk("t4a_no_hs", hs - h, 0);
        // redirect in HOLD with consumption
        step();
        step();
        chk("t4b_pc", inst_pc, 32'h8000_0180);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        h = hs;
        step();
        redirect_valid = 1'b0;
        chk("t4b_one_hs", hs - h, 1);
        chk("t4b_req_addr", imem_req_addr, 32'h8000_0300);
        chk("t4b_no_inst", {31'h0, inst_valid}, 32'h0);
        // redirect on an accepted request to a misaligned PC
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("t5b_in_wait", {31'h0, imem_req_valid}, 32'h0);
        wait_inst("t5b_wait_inst");
        chk("t5b_pc", inst_pc, 32'h8000_0102);
        chk("t5b_inst", inst, 32'h0);
        chk("t5b_fault", {31'h0, fetch_fault}, 32'h1);
        // redirects while the request is stalled, then PC wrap
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0500;
        step();
        chk("t6_addr_a", imem_req_addr, 32'h8000_0500);
        chk("t6_squash", {31'h0, inst_valid}, 32'h0);
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("t6_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t6_addr_b", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        step();
        step();
        chk("t6_pc", inst_pc, 32'hFFFF_FFFC);
        step();
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        // asynchronous reset mid-transaction, then redirect out of IDLE
        step();
        rst = 1'b1;
        #1;
        chk("t7_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("t7_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t7_req_addr", imem_req_addr, 32'h8000_0000);
        step();
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0700;
        step();
        redirect_valid = 1'b0;
        chk("t7_req_valid_b", {31'h0, imem_req_valid}, 32'h1);
        chk("t7_addr", imem_req_addr, 32'h8000_0700);
        step();
        step();
        chk("t7_inst_valid_b", {31'h0, inst_valid}, 32'h1);
        chk("t7_pc", inst_pc, 32'h8000_0700);
        // steady-state throughput: three cycles per instruction
        step();
        chk("t8_req_valid", {31'h0, imem_req_valid}, 32'h1);
        h = hs;
        for (int i = 0; i < 9; i++) step();
        chk("t8_throughput", hs - h, 3);
        chk("no_deadbeef", {31'h0, seen_dead}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
